weight_preload_sequencer: RTL and testbench

Upstream sequencer for the systolic MAC mesh top level. It accepts one weight matrix as a valid/ready stream in row-major order and drives the mesh preload port, one entry per accepted word. It then issues a single-cycle `start` pulse to the mesh FSM, times the compute window and reports completion, so a host only pushes weights and waits for `done`.

---
 rtl/weight_preload_sequencer.sv | 126 ++++++++++++
 tb/tb_weight_preload_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_preload_sequencer.sv
// Streams one ROWS x COLS weight matrix into the mesh preload port, then pulses
// start, times the compute window and pulses done.
`timescale 1ns/1ps
module weight_preload_sequencer #(
   parameter int DW         = 8,
   parameter int ROWS       = 16,
   parameter int COLS       = 16,
   parameter int ROW_W      = 4,
   parameter int COL_W      = 4,
   parameter int RUN_CYCLES = 40
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        load_req,
   input  logic                        w_valid,
   output logic                        w_ready,
   input  logic signed [DW-1:0]        w_data,
   output logic                        preload_valid,
   output logic [ROW_W+COL_W-1:0]      preload_addr,
   output logic signed [DW-1:0]        preload_data,
   output logic                        start,
   output logic                        busy,
   output logic                        done
);

   localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIRE, S_RUN} state_t;

   state_t                     state_q, state_d;
   logic [ROW_W-1:0]           row_q, row_d;
   logic [COL_W-1:0]           col_q, col_d;
   logic [RUN_W-1:0]           run_q, run_d;
   logic                       pv_q, pv_d;
   logic [ROW_W+COL_W-1:0]     addr_q, addr_d;
   logic signed [DW-1:0]       data_q, data_d;
   logic                       start_q, start_d;
   logic                       done_q, done_d;
   logic                       hs;

   assign hs = (state_q == S_LOAD) && w_valid;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      run_d   = run_q;
      pv_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      start_d = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            row_d = '0;
            col_d = '0;
            if (load_req) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (hs) begin
               pv_d   = 1'b1;
               addr_d = {row_q, col_q};
               data_d = w_data;
               // Column wraps at COLS-1 so non-power-of-two widths stay gapless
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (row_q == ROW_LAST) state_d = S_FIRE;
                  else                   row_d   = row_q + ROW_W'(1);
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end
         S_FIRE: begin
            start_d = 1'b1;
            run_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (run_q == RUN_LAST) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               run_d = run_q + RUN_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         run_q   <= '0;
         pv_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         run_q   <= run_d;
         pv_q    <= pv_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         start_q <= start_d;
         done_q  <= done_d;
      end
   end

   assign w_ready       = (state_q == S_LOAD);
   assign busy          = (state_q != S_IDLE);
   assign preload_valid = pv_q;
   assign preload_addr  = addr_q;
   assign preload_data  = data_q;
   assign start         = start_q;
   assign done          = done_q;

endmodule

// File: tb/tb_weight_preload_sequencer.sv
// Bench: a 16x16 instance and a 3x5 instance share stimulus; each is checked
// every cycle against a word-count/timestamp model, plus a vector table and directed runs.
`timescale 1ns/1ps
module tb_weight_preload_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0, load_req = 1'b0, w_valid = 1'b0;
   logic [7:0] w_data = '0;

   logic       a_ready, a_pv, a_start, a_busy, a_done;
   logic [7:0] a_addr, a_data;
   logic       b_ready, b_pv, b_start, b_busy, b_done;
   logic [7:0] b_addr, b_data;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   weight_preload_sequencer dut_a (
      .clk(clk), .rst_n(rst_n), .load_req(load_req), .w_valid(w_valid),
      .w_ready(a_ready), .w_data(w_data), .preload_valid(a_pv),
      .preload_addr(a_addr), .preload_data(a_data), .start(a_start),
      .busy(a_busy), .done(a_done));

   weight_preload_sequencer #(.DW(8), .ROWS(3), .COLS(5), .ROW_W(4), .COL_W(4), .RUN_CYCLES(6)) dut_b (
      .clk(clk), .rst_n(rst_n), .load_req(load_req), .w_valid(w_valid),
      .w_ready(b_ready), .w_data(w_data), .preload_valid(b_pv),
      .preload_addr(b_addr), .preload_data(b_data), .start(b_start),
      .busy(b_busy), .done(b_done));

   // Model: words accepted so far plus the cycle numbers of expected pulses.
   typedef struct {
      bit         loading;
      int         cnt;
      int         last_busy;
      int         t_start;
      int         t_done;
      bit         rst_now;
      bit         pv;
      int         addr;
      logic [7:0] data;
      bit         ready, busy, start, done;
   } model_t;

   model_t mA, mB;

   function automatic model_t mstep(model_t m, int rows, int cols, int run,
                                    bit r, bit lr, bit wv, logic [7:0] wd, int now);
      bit was_loading, was_idle;
      m.pv = 0;
      m.rst_now = 0;
      if (!r) begin
         m.loading = 0; m.cnt = 0; m.rst_now = 1;
         m.last_busy = -1000; m.t_start = -1000; m.t_done = -1000;
         m.addr = 0; m.data = '0;
      end else begin
         was_loading = m.loading;
         was_idle    = !m.loading && (now - 1 > m.last_busy);
         if (was_loading && wv) begin
            m.pv   = 1;
            m.addr = ((m.cnt / cols) << 4) | (m.cnt % cols);
            m.data = wd;
            m.cnt++;
            if (m.cnt == rows * cols) begin
               m.loading   = 0;
               m.t_start   = now + 1;
               m.last_busy = now + run;
               m.t_done    = now + 1 + run;
            end
         end else if (was_idle && lr) begin
            m.loading = 1;
            m.cnt     = 0;
         end
      end
      m.ready = m.loading;
      m.busy  = m.loading || (now <= m.last_busy);
      m.start = (now == m.t_start);
      m.done  = (now == m.t_done);
      return m;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(bit r, bit lr, bit wv, logic [7:0] wd);
      rst_n = r; load_req = lr; w_valid = wv; w_data = wd;
      @(posedge clk);
      cyc++;
      mA = mstep(mA, 16, 16, 40, r, lr, wv, wd, cyc);
      mB = mstep(mB, 3, 5, 6, r, lr, wv, wd, cyc);
      #1;
      chk("A.w_ready", a_ready, mA.ready);
      chk("A.busy",    a_busy,  mA.busy);
      chk("A.pvalid",  a_pv,    mA.pv);
      chk("A.start",   a_start, mA.start);
      chk("A.done",    a_done,  mA.done);
      if (mA.pv || mA.rst_now) begin
         chk("A.paddr", a_addr, mA.addr);
         chk("A.pdata", a_data, mA.data);
      end
      chk("B.w_ready", b_ready, mB.ready);
      chk("B.busy",    b_busy,  mB.busy);
      chk("B.pvalid",  b_pv,    mB.pv);
      chk("B.start",   b_start, mB.start);
      chk("B.done",    b_done,  mB.done);
      if (mB.pv || mB.rst_now) begin
         chk("B.paddr", b_addr, mB.addr);
         chk("B.pdata", b_data, mB.data);
      end
   endtask

   typedef struct {
      bit         r, lr, wv;
      logic [7:0] wd;
      bit         e_ready, e_pv;
      logic [7:0] e_addr, e_data;
      bit         e_start, e_busy, e_done;
   } vec_t;

   vec_t tbl[13];
   int   exp_b[15] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                       8'h10, 8'h11, 8'h12, 8'h13, 8'h14,
                       8'h20, 8'h21, 8'h22, 8'h23, 8'h24};

   initial begin
      int  npv, t0, nstart, first_addr;
      bit  found;

      tbl[0]  = '{0,0,1,8'hAA, 0,0,8'h00,8'h00, 0,0,0};
      tbl[1]  = '{0,0,1,8'hAA, 0,0,8'h00,8'h00, 0,0,0};
      tbl[2]  = '{1,0,1,8'hAA, 0,0,8'h00,8'h00, 0,0,0};
      tbl[3]  = '{1,0,1,8'h55, 0,0,8'h00,8'h00, 0,0,0};
      tbl[4]  = '{1,1,1,8'hAA, 1,0,8'h00,8'h00, 0,1,0};
      tbl[5]  = '{1,0,1,8'h11, 1,1,8'h00,8'h11, 0,1,0};
      tbl[6]  = '{1,1,0,8'h22, 1,0,8'h00,8'h00, 0,1,0};
      tbl[7]  = '{1,0,1,8'hF3, 1,1,8'h01,8'hF3, 0,1,0};
      tbl[8]  = '{1,0,1,8'h7F, 1,1,8'h02,8'h7F, 0,1,0};
      tbl[9]  = '{0,0,1,8'h99, 0,0,8'h00,8'h00, 0,0,0};
      tbl[10] = '{1,0,1,8'h44, 0,0,8'h00,8'h00, 0,0,0};
      tbl[11] = '{1,1,0,8'h00, 1,0,8'h00,8'h00, 0,1,0};
      tbl[12] = '{1,0,1,8'h05, 1,1,8'h00,8'h05, 0,1,0};

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].r, tbl[i].lr, tbl[i].wv, tbl[i].wd);
         chk("T.w_ready", a_ready, tbl[i].e_ready);
         chk("T.pvalid",  a_pv,    tbl[i].e_pv);
         chk("T.start",   a_start, tbl[i].e_start);
         chk("T.busy",    a_busy,  tbl[i].e_busy);
         chk("T.done",    a_done,  tbl[i].e_done);
         if (tbl[i].e_pv || !tbl[i].r) begin
            chk("T.paddr", a_addr, tbl[i].e_addr);
            chk("T.pdata", a_data, tbl[i].e_data);
         end
      end

      // Reset then idle with w_valid high: nothing consumed
      step(0,0,0,0); step(0,0,0,0);
      for (int i = 0; i < 10; i++) begin
         step(1,0,1,8'($urandom));
         chk("idle.outputs", {a_ready,a_pv,a_start,a_busy,a_done}, 5'b0);
      end

      // Full back-to-back load with ignored load_req during LOAD and RUN
      step(0,0,0,0); step(0,0,0,0);
      step(1,1,0,0);
      npv = 0;
      for (int i = 0; i < 256; i++) begin
         step(1, (i == 50), 1, 8'(i));
         if (a_pv && a_addr == 8'(i) && a_data == 8'(i)) npv++;
      end
      chk("b2b.pv_count", npv, 256);
      step(1,0,0,0);
      chk("b2b.start_after_last", a_start, 1);
      t0 = cyc;
      found = 0;
      for (int k = 0; k < 60 && !found; k++) begin
         step(1, (k == 10), 0, 0);
         if (a_done) begin
            found = 1;
            chk("b2b.done_delay", cyc - t0, 40);
         end
      end
      if (!found) chk("b2b.done_timeout", 0, 1);
      step(1,0,0,0);
      chk("b2b.busy_after_done", a_busy, 0);
      step(1,1,0,0);
      chk("reload.w_ready", a_ready, 1);
      step(1,0,1,8'h5A);
      chk("reload.first_addr", {a_pv, a_addr}, {1'b1, 8'h00});

      // 3x5 instance: gapless row/column addressing
      step(0,0,0,0); step(0,0,0,0);
      step(1,1,0,0);
      for (int i = 0; i < 15; i++) begin
         step(1,0,1,8'($urandom));
         chk("np2.addr", {b_pv, b_addr}, {1'b1, 8'(exp_b[i])});
      end
      step(1,0,0,0);
      chk("np2.start", {b_start, b_pv}, 2'b10);

      // Stalled stream with 50% random valid
      step(0,0,0,0); step(0,0,0,0);
      step(1,1,0,0);
      nstart = 0;
      found  = 0;
      for (int k = 0; k < 3000 && !found; k++) begin
         step(1, 0, 1'($urandom % 2), 8'($urandom));
         if (a_start) nstart++;
         if (a_done) found = 1;
      end
      if (!found) chk("stall.done_timeout", 0, 1);
      chk("stall.start_once", nstart, 1);

      // Reset mid-load, then a complete load from address 0
      step(0,0,0,0); step(0,0,0,0);
      step(1,1,0,0);
      for (int i = 0; i < 100; i++) step(1,0,1,8'($urandom));
      step(0,0,1,8'hEE);
      chk("midrst.outputs", {a_ready,a_pv,a_start,a_busy,a_done,a_addr,a_data}, '0);
      step(1,1,0,0);
      step(1,0,1,8'h33);
      first_addr = a_addr;
      chk("midrst.restart_addr", {a_pv, 8'(first_addr)}, {1'b1, 8'h00});
      found = 0;
      for (int k = 0; k < 400 && !found; k++) begin
         step(1,0,1,8'($urandom));
         if (a_done) found = 1;
      end
      if (!found) chk("midrst.done_timeout", 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
